// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single write port of the 32-entry integer
// register file. It arbitrates ALU/LSU writeback (LSU preferred, with ALU
// starvation protection), registers the winning write onto wrEn/rd/dIn, and
// keeps a pending-write scoreboard for the RAW/WAW stall checks in issue.
// Optional feature macro: REGFILE_BYPASS_EN adds forwarding of the in-flight
// write stage (rs1_fwd, rs2_fwd, fwd_data) instead of reporting it as busy.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef REGFILE_BYPASS_EN
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic                  wrEn,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] dIn
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;
  logic        alu_nz;
  logic        lsu_nz;
  logic        alu_win;
  logic        lsu_win;
  logic        issue_set;

  // Arbitration: rd==0 requests are absorbed; one nonzero-rd winner per cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_nz     = alu_valid & (alu_rd != 5'd0);
    lsu_nz     = lsu_valid & (lsu_rd != 5'd0);
    alu_win    = alu_nz & (!lsu_nz | (starve_cnt == STARVE_LIM));
    lsu_win    = lsu_nz & !alu_win;
    alu_ready  = !rst & alu_valid & ((alu_rd == 5'd0) | alu_win);
    lsu_ready  = !rst & lsu_valid & ((lsu_rd == 5'd0) | lsu_win);
    starve_nxt = 4'd0;
    if (alu_nz && !alu_win) begin
      starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  // Scoreboard next state: writeback clears, then an accepted issue sets (set wins).
  always_comb begin
    issue_ready = rst | (issue_rd == 5'd0) | !pending[issue_rd];
    issue_set   = issue_valid & issue_ready & (issue_rd != 5'd0);
    pending_nxt = pending;
    if (alu_win) begin
      pending_nxt[alu_rd] = 1'b0;
    end else if (lsu_win) begin
      pending_nxt[lsu_rd] = 1'b0;
    end
    if (issue_set) begin
      pending_nxt[issue_rd] = 1'b1;
    end
  end

  // Source-operand hazard flags for the instruction sitting in decode.
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs1_busy = !rst & (rs1 != 5'd0) & pending[rs1];
    rs2_busy = !rst & (rs2 != 5'd0) & pending[rs2];
    rs1_fwd  = wrEn & (rd == rs1) & (rs1 != 5'd0);
    rs2_fwd  = wrEn & (rd == rs2) & (rs2 != 5'd0);
    fwd_data = dIn;
  end
`else
  always_comb begin
    rs1_busy = !rst & (rs1 != 5'd0) & (pending[rs1] | (wrEn & (rd == rs1)));
    rs2_busy = !rst & (rs2 != 5'd0) & (pending[rs2] | (wrEn & (rd == rs2)));
  end
`endif

  // State: write stage, scoreboard and starvation counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      // NOTE: the pending array is plain flops and must be reset, otherwise stale bits stall issue forever.
      pending    <= '0;
      starve_cnt <= '0;
      wrEn       <= 1'b0;
      rd         <= '0;
      dIn        <= '0;
    end else begin
      pending    <= pending_nxt;
      starve_cnt <= starve_nxt;
      if (alu_win) begin
        wrEn <= 1'b1;
        rd   <= alu_rd;
        dIn  <= alu_data;
      end else if (lsu_win) begin
        wrEn <= 1'b1;
        rd   <= lsu_rd;
        dIn  <= lsu_data;
      end else begin
        wrEn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a directed vector table for the documented
// scenarios, then randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int DW    = 32;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, lsu_valid, issue_valid;
  logic [4:0]    alu_rd, lsu_rd, issue_rd, rs1, rs2;
  logic [DW-1:0] alu_data, lsu_data;
  logic          alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy;
  logic          wr_en;
  logic [4:0]    wr_rd;
  logic [DW-1:0] wr_din;
`ifdef REGFILE_BYPASS_EN
  logic          rs1_fwd, rs2_fwd;
  logic [DW-1:0] fwd_data;
`endif

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REGFILE_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data),
`endif
    .wrEn(wr_en), .rd(wr_rd), .dIn(wr_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          av;  logic [4:0] ard; logic [31:0] ad;
    bit          lv;  logic [4:0] lrd; logic [31:0] ld;
    bit          iv;  logic [4:0] ird;
    logic [4:0]  s1;  logic [4:0] s2;
    bit          ar, lr, ir, b1, b2, we;
    logic [4:0]  erd; logic [31:0] edin;
  } vec_t;

  function automatic vec_t mk(bit r, bit av, int ard, int ad, bit lv, int lrd, int ld,
                              bit iv, int ird, int s1, int s2,
                              bit ar, bit lr, bit ir, bit b1, bit b2, bit we, int erd, int edin);
    vec_t v;
    v.rst = r;  v.av = av; v.ard = 5'(ard); v.ad = 32'(ad);
    v.lv = lv;  v.lrd = 5'(lrd); v.ld = 32'(ld);
    v.iv = iv;  v.ird = 5'(ird); v.s1 = 5'(s1); v.s2 = 5'(s2);
    v.ar = ar;  v.lr = lr; v.ir = ir; v.b1 = b1; v.b2 = b2; v.we = we;
    v.erd = 5'(erd); v.edin = 32'(edin);
    return v;
  endfunction

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: pending set, count of consecutive ALU losses, write stage.
  bit          m_pend [32];
  int          m_losses;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_din;
  bit          e_ar, e_lr, e_ir, e_b1, e_b2, e_f1, e_f2;
  int          winner; // 0 none, 1 ALU, 2 LSU

  function automatic bit stale(input logic [4:0] r);
    if (r == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    return m_pend[r];
`else
    return m_pend[r] || (m_we && m_rd == r);
`endif
  endfunction

  task automatic model_eval();
    bit a_real, l_real;
    a_real = alu_valid && alu_rd != 0;
    l_real = lsu_valid && lsu_rd != 0;
    if (a_real && l_real) winner = (m_losses >= LIMIT) ? 1 : 2;
    else if (a_real)      winner = 1;
    else if (l_real)      winner = 2;
    else                  winner = 0;
    e_f1 = m_we && m_rd == rs1 && rs1 != 0;
    e_f2 = m_we && m_rd == rs2 && rs2 != 0;
    if (rst) begin
      e_ar = 0; e_lr = 0; e_ir = 1; e_b1 = 0; e_b2 = 0;
    end else begin
      e_ar = alu_valid && (alu_rd == 0 || winner == 1);
      e_lr = lsu_valid && (lsu_rd == 0 || winner == 2);
      e_ir = (issue_rd == 0) || !m_pend[issue_rd];
      e_b1 = stale(rs1);
      e_b2 = stale(rs2);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_losses = 0; m_we = 0; m_rd = 0; m_din = 0;
      return;
    end
    if (winner == 1) begin
      m_we = 1; m_rd = alu_rd; m_din = alu_data; m_pend[alu_rd] = 0;
    end else if (winner == 2) begin
      m_we = 1; m_rd = lsu_rd; m_din = lsu_data; m_pend[lsu_rd] = 0;
    end else begin
      m_we = 0;
    end
    if (issue_valid && e_ir && issue_rd != 0) m_pend[issue_rd] = 1;
    if (alu_valid && alu_rd != 0 && winner != 1) m_losses = (m_losses < 15) ? m_losses + 1 : 15;
    else m_losses = 0;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    issue_valid = v.iv; issue_rd = v.ird; rs1 = v.s1; rs2 = v.s2;
  endtask

  task automatic compare_model();
    check("alu_ready", alu_ready, e_ar);
    check("lsu_ready", lsu_ready, e_lr);
    check("issue_ready", issue_ready, e_ir);
    check("rs1_busy", rs1_busy, e_b1);
    check("rs2_busy", rs2_busy, e_b2);
    check("wrEn", wr_en, m_we);
    check("rd", wr_rd, m_rd);
    check("dIn", wr_din, m_din);
`ifdef REGFILE_BYPASS_EN
    check("rs1_fwd", rs1_fwd, e_f1);
    check("rs2_fwd", rs2_fwd, e_f2);
    check("fwd_data", fwd_data, m_din);
`endif
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,1,0,0, 0,0,0);
    // reset with stale request inputs, then the documented scenarios
    tbl.push_back(mk(1, 1,3,'h33, 1,4,'h44, 1,5, 5,0,  0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    0,0, 0,0,  0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    1,5, 0,0,  0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0, 1,5,'hAA, 0,0,0,    0,0, 5,0,  1,0,1,1,0, 0,0,0));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    0,0, 5,0,  0,0,1,1,0, 1,5,'hAA));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    0,0, 5,0,  0,0,1,0,0, 0,5,'hAA));
    tbl.push_back(mk(0, 1,3,'h33, 1,4,'h44, 0,0, 0,0,  0,1,1,0,0, 0,5,'hAA));
    tbl.push_back(mk(0, 1,3,'h33, 0,0,0,    0,0, 0,0,  1,0,1,0,0, 1,4,'h44));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    0,0, 0,0,  0,0,1,0,0, 1,3,'h33));
    // starvation: ALU rd=7 loses three times, wins on the fourth
    tbl.push_back(mk(0, 1,7,'h77, 1,8,'h88, 0,0, 0,0,  0,1,1,0,0, 0,3,'h33));
    tbl.push_back(mk(0, 1,7,'h77, 1,8,'h88, 0,0, 0,0,  0,1,1,0,0, 1,8,'h88));
    tbl.push_back(mk(0, 1,7,'h77, 1,8,'h88, 0,0, 0,0,  0,1,1,0,0, 1,8,'h88));
    tbl.push_back(mk(0, 1,7,'h77, 1,8,'h88, 0,0, 0,0,  1,0,1,0,0, 1,8,'h88));
    tbl.push_back(mk(0, 1,7,'h77, 1,8,'h88, 0,0, 0,0,  0,1,1,0,0, 1,7,'h77));
    // ALU rd=0 and LSU rd=9 together
    tbl.push_back(mk(0, 1,0,'h11, 1,9,'h99, 0,0, 0,0,  1,1,1,0,0, 1,8,'h88));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    0,0, 0,0,  0,0,1,0,0, 1,9,'h99));
    // scoreboard: pending blocks issue, set wins over same-cycle clear
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    1,6, 0,0,  0,0,1,0,0, 0,9,'h99));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    1,6, 0,0,  0,0,0,0,0, 0,9,'h99));
    tbl.push_back(mk(0, 0,0,0,    1,6,'h66, 1,6, 0,0,  0,1,0,0,0, 0,9,'h99));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    1,6, 0,6,  0,0,1,0,1, 1,6,'h66));
    tbl.push_back(mk(0, 0,0,0,    1,10,'hA0,1,10,0,6,  0,1,1,0,1, 0,6,'h66));
    tbl.push_back(mk(0, 1,11,'hB1,0,0,0,    1,10,10,6, 1,0,0,1,1, 1,10,'hA0));
    // reset mid-operation drops the in-flight write and pending bits
    tbl.push_back(mk(1, 1,12,'hC, 0,0,0,    1,10,10,6, 0,0,1,0,0, 1,11,'hB1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    1,6, 10,6, 0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,    1,6, 0,6,  0,0,0,0,1, 0,0,0));

    begin
      vec_t r0;
      r0 = idle; r0.rst = 1;
      drive(r0);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk); drive(r0); #1; model_eval(); model_step();
      end
    end

    foreach (tbl[i]) begin
      @(negedge clk); cyc++;
      drive(tbl[i]); #1;
      model_eval();
      check($sformatf("v%0d alu_ready", i), alu_ready, tbl[i].ar);
      check($sformatf("v%0d lsu_ready", i), lsu_ready, tbl[i].lr);
      check($sformatf("v%0d issue_ready", i), issue_ready, tbl[i].ir);
`ifdef REGFILE_BYPASS_EN
      check($sformatf("v%0d rs1_busy", i), rs1_busy, e_b1);
      check($sformatf("v%0d rs2_busy", i), rs2_busy, e_b2);
`else
      check($sformatf("v%0d rs1_busy", i), rs1_busy, tbl[i].b1);
      check($sformatf("v%0d rs2_busy", i), rs2_busy, tbl[i].b2);
`endif
      check($sformatf("v%0d wrEn", i), wr_en, tbl[i].we);
      check($sformatf("v%0d rd", i), wr_rd, tbl[i].erd);
      check($sformatf("v%0d dIn", i), wr_din, tbl[i].edin);
      model_step();
    end

`ifdef REGFILE_BYPASS_EN
    // in-flight write to a non-pending register is forwarded, not stalled
    begin
      vec_t b;
      b = idle; b.lv = 1; b.lrd = 2; b.ld = 'h55;
      @(negedge clk); cyc++; drive(b); #1; model_eval(); model_step();
      b = idle; b.s2 = 2;
      @(negedge clk); cyc++; drive(b); #1; model_eval();
      check("byp rs2_fwd", rs2_fwd, 1'b1);
      check("byp fwd_data", fwd_data, 32'h55);
      check("byp rs2_busy", rs2_busy, 1'b0);
      model_step();
    end
`endif

    // randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      v = idle;
      v.rst = ($urandom_range(0, 59) == 0);
      v.av  = $urandom_range(0, 1); v.ard = 5'($urandom_range(0, 7)); v.ad = $urandom;
      v.lv  = $urandom_range(0, 1); v.lrd = 5'($urandom_range(0, 7)); v.ld = $urandom;
      v.iv  = $urandom_range(0, 1); v.ird = 5'($urandom_range(0, 7));
      v.s1  = 5'($urandom_range(0, 7)); v.s2 = 5'($urandom_range(0, 7));
      @(negedge clk); cyc++;
      drive(v); #1;
      model_eval();
      compare_model();
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
